// File: rtl/axi_id_remap_alloc.sv
// Dynamic AXI ID narrowing: binds each live wide master ID to one narrow slot,
// counts outstanding beats per slot and restores the wide ID on responses.

module axi_id_remap_slot #(
  parameter int IN_ID_WIDTH      = 8,
  parameter int ACTIVE_CNT_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IN_ID_WIDTH-1:0]      req_id,
  input  logic                        commit,
  input  logic                        rel,
  output logic [IN_ID_WIDTH-1:0]      orig_id,
  output logic [ACTIVE_CNT_WIDTH-1:0] cnt,
  output logic                        underflow
);
  logic live;

  assign live      = cnt != '0;
  assign underflow = rel && !live;

  // A release on an idle slot is dropped so the count never wraps below zero;
  // commit and release together on a live slot cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      orig_id <= '0;
      cnt     <= '0;
    end else begin
      if (commit) orig_id <= req_id;
      if (commit && !(rel && live)) cnt <= cnt + 1'b1;
      else if (!commit && rel && live) cnt <= cnt - 1'b1;
    end
  end
endmodule

module axi_id_remap_alloc #(
  parameter int IN_ID_WIDTH      = 8,
  parameter int OUT_ID_WIDTH     = 2,
  parameter int ACTIVE_CNT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [IN_ID_WIDTH-1:0]  req_id,
  output logic                    fwd_valid,
  input  logic                    fwd_ready,
  output logic [OUT_ID_WIDTH-1:0] fwd_id,
  input  logic                    rel_valid,
  input  logic [OUT_ID_WIDTH-1:0] rel_id,
  output logic [IN_ID_WIDTH-1:0]  rel_orig_id,
  output logic                    busy,
  output logic                    err_underflow
);
  localparam int NSLOT = 1 << OUT_ID_WIDTH;
  localparam logic [ACTIVE_CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [NSLOT-1:0][IN_ID_WIDTH-1:0]      orig_q;
  logic [NSLOT-1:0][ACTIVE_CNT_WIDTH-1:0] cnt_q;
  logic [NSLOT-1:0] live, hit_vec, commit, rel, uf;
  logic [OUT_ID_WIDTH-1:0] hit_idx, free_idx;
  logic hit, free_any, grant;

  genvar g;
  generate
    for (g = 0; g < NSLOT; g++) begin : g_slot
      assign live[g]    = cnt_q[g] != '0;
      assign hit_vec[g] = live[g] && (orig_q[g] == req_id);
      assign commit[g]  = req_ready && (fwd_id == OUT_ID_WIDTH'(g));
      assign rel[g]     = rel_valid && (rel_id == OUT_ID_WIDTH'(g));

      axi_id_remap_slot #(
        .IN_ID_WIDTH      (IN_ID_WIDTH),
        .ACTIVE_CNT_WIDTH (ACTIVE_CNT_WIDTH)
      ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .req_id    (req_id),
        .commit    (commit[g]),
        .rel       (rel[g]),
        .orig_id   (orig_q[g]),
        .cnt       (cnt_q[g]),
        .underflow (uf[g])
      );
    end
  endgenerate

  // Lookup sees only registered state, so a slot freed this cycle is not reused until next.
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    free_any = 1'b0;
    for (int i = 0; i < NSLOT; i++)
      if (hit_vec[i]) hit_idx = OUT_ID_WIDTH'(i);
    for (int i = NSLOT - 1; i >= 0; i--)
      if (!live[i]) begin
        free_idx = OUT_ID_WIDTH'(i);
        free_any = 1'b1;
      end
  end

  // A live ID at saturation stalls rather than spilling into a second slot.
  assign hit       = |hit_vec;
  assign grant     = hit ? (cnt_q[hit_idx] != CNT_MAX) : free_any;
  assign fwd_id    = hit ? hit_idx : free_idx;
  assign fwd_valid = req_valid && grant;
  assign req_ready = fwd_valid && fwd_ready;

  assign rel_orig_id = orig_q[rel_id];
  assign busy        = |live;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      err_underflow <= 1'b0;
    else if (|uf) err_underflow <= 1'b1;
  end
endmodule

// File: tb/tb_axi_id_remap_alloc.sv
// Randomized and directed check of axi_id_remap_alloc against a slot-table model.

module tb_axi_id_remap_alloc;
  localparam int IW    = 8;
  localparam int OW    = 2;
  localparam int CW    = 2;
  localparam int NSLOT = 1 << OW;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk, rst;
  logic req_valid, req_ready, fwd_valid, fwd_ready, rel_valid, busy, err_underflow;
  logic [IW-1:0] req_id, rel_orig_id;
  logic [OW-1:0] fwd_id, rel_id;

  int n_chk, n_fail;

  // model state: which wide ID each slot holds and how many beats are outstanding
  int m_orig [NSLOT];
  int m_cnt  [NSLOT];
  bit m_err;

  axi_id_remap_alloc #(.IN_ID_WIDTH(IW), .OUT_ID_WIDTH(OW), .ACTIVE_CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_id(fwd_id),
    .rel_valid(rel_valid), .rel_id(rel_id), .rel_orig_id(rel_orig_id),
    .busy(busy), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NSLOT; s++) begin
      m_orig[s] = 0;
      m_cnt[s]  = 0;
    end
    m_err = 1'b0;
  endtask

  // One clock: drive, check combinational outputs against the model, advance the model.
  task automatic step(input bit rv, input int rid, input bit fr, input bit lv, input int lid,
                      output bit o_fv, output bit o_rdy, output int o_id, output int o_orig);
    int hit, free, slot, pre;
    bit grant, e_fv, e_rdy, e_busy;
    req_valid = rv; req_id = IW'(rid); fwd_ready = fr; rel_valid = lv; rel_id = OW'(lid);
    #3;
    hit = -1; free = -1; e_busy = 1'b0;
    for (int s = 0; s < NSLOT; s++) begin
      if (m_cnt[s] > 0 && m_orig[s] == rid) hit = s;
      if (m_cnt[s] > 0) e_busy = 1'b1;
    end
    for (int s = NSLOT - 1; s >= 0; s--)
      if (m_cnt[s] == 0) free = s;
    grant = (hit >= 0) ? (m_cnt[hit] < CMAX) : (free >= 0);
    slot  = (hit >= 0) ? hit : free;
    e_fv  = rv && grant;
    e_rdy = e_fv && fr;
    o_fv = fwd_valid; o_rdy = req_ready; o_id = int'(fwd_id); o_orig = int'(rel_orig_id);
    chk("fwd_valid", fwd_valid, e_fv);
    chk("req_ready", req_ready, e_rdy);
    if (e_fv) chk("fwd_id", fwd_id, slot);
    chk("rel_orig_id", rel_orig_id, m_orig[lid]);
    chk("busy", busy, e_busy);
    chk("err_underflow", err_underflow, m_err);
    @(posedge clk);
    pre = m_cnt[lid];
    if (e_rdy) begin
      m_orig[slot] = rid;
      m_cnt[slot]++;
    end
    if (lv) begin
      if (pre == 0) m_err = 1'b1;
      else m_cnt[lid]--;
    end
    #1;
  endtask

  bit fv, rdy;
  int id, orig;

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; req_valid = 0; req_id = '0; fwd_ready = 0; rel_valid = 0; rel_id = '0;
    model_reset();
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_fwd_id", fwd_id, 0);
    chk("rst_err", err_underflow, 0);
    @(posedge clk); #1 rst = 1'b0;

    // cold allocation
    step(1, 'h35, 1, 0, 0, fv, rdy, id, orig); chk("cold_rdy", rdy, 1); chk("cold_id", id, 0);
    step(1, 'h35, 1, 0, 0, fv, rdy, id, orig); chk("cold_reuse_id", id, 0);
    step(1, 'h80, 1, 0, 0, fv, rdy, id, orig); chk("cold_second_id", id, 1);
    step(0, 0, 0, 1, 0, fv, rdy, id, orig);
    step(0, 0, 0, 1, 0, fv, rdy, id, orig);
    step(0, 0, 0, 1, 1, fv, rdy, id, orig);
    step(0, 0, 0, 0, 0, fv, rdy, id, orig);

    // pool full, then release of slot 2 is visible one cycle later
    for (int i = 0; i < 4; i++) step(1, 'h10 + i, 1, 0, 0, fv, rdy, id, orig);
    step(1, 'h14, 1, 0, 0, fv, rdy, id, orig); chk("full_stall", rdy, 0);
    step(1, 'h14, 1, 1, 2, fv, rdy, id, orig); chk("full_rel_same_cycle", rdy, 0);
    step(1, 'h14, 1, 0, 0, fv, rdy, id, orig); chk("full_grant_rdy", rdy, 1); chk("full_grant_id", id, 2);

    // same-slot commit+release, and freed slot not reusable in the same cycle
    step(1, 'h10, 1, 1, 0, fv, rdy, id, orig); chk("same_slot_rdy", rdy, 1); chk("same_slot_id", id, 0);
    step(1, 'h20, 1, 1, 1, fv, rdy, id, orig); chk("freed_stall", rdy, 0);
    step(1, 'h20, 1, 0, 0, fv, rdy, id, orig); chk("freed_next_rdy", rdy, 1); chk("freed_next_id", id, 1);
    for (int s = 0; s < NSLOT; s++) step(0, 0, 0, 1, s, fv, rdy, id, orig);

    // count saturation at CMAX = 3
    for (int i = 0; i < 3; i++) step(1, 'h07, 1, 0, 0, fv, rdy, id, orig);
    step(1, 'h07, 1, 0, 0, fv, rdy, id, orig); chk("sat_stall", rdy, 0);
    step(1, 'h07, 1, 1, 0, fv, rdy, id, orig); chk("sat_stall_rel", rdy, 0);
    step(1, 'h07, 1, 0, 0, fv, rdy, id, orig); chk("sat_after_rel_rdy", rdy, 1); chk("sat_after_rel_id", id, 0);

    // response restore and underflow
    step(1, 'hA1, 1, 0, 0, fv, rdy, id, orig);
    step(1, 'hA2, 1, 0, 0, fv, rdy, id, orig);
    step(1, 'hA7, 1, 0, 0, fv, rdy, id, orig); chk("a7_slot", id, 3);
    step(0, 0, 0, 1, 3, fv, rdy, id, orig); chk("restore_a7", orig, 'hA7);
    step(0, 0, 0, 1, 2, fv, rdy, id, orig);
    step(0, 0, 0, 1, 2, fv, rdy, id, orig);
    step(0, 0, 0, 0, 2, fv, rdy, id, orig); chk("underflow_sticky", err_underflow, 1);

    // backpressure
    for (int i = 0; i < 5; i++) begin
      step(1, 'h55, 0, 0, 0, fv, rdy, id, orig);
      chk("bp_fwd_valid", fv, 1); chk("bp_req_ready", rdy, 0);
    end
    step(1, 'h55, 1, 0, 0, fv, rdy, id, orig); chk("bp_release_id", id, 2);

    // asynchronous reset mid-operation with three slots live
    rst = 1'b1; #1;
    model_reset();
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err_underflow, 0);
    @(posedge clk); #1 rst = 1'b0;
    step(1, 'h55, 1, 0, 0, fv, rdy, id, orig); chk("post_rst_id", id, 0);

    // random traffic over a small ID set so hits, saturation and pool-full all recur
    for (int n = 0; n < 2000; n++) begin
      int lid, live_cnt;
      int live_list[$];
      live_list.delete();
      for (int s = 0; s < NSLOT; s++) if (m_cnt[s] > 0) live_list.push_back(s);
      live_cnt = live_list.size();
      lid = (live_cnt > 0 && $urandom_range(9) < 8) ? live_list[$urandom_range(live_cnt - 1)]
                                                     : int'($urandom_range(NSLOT - 1));
      step($urandom_range(3) != 0, 'h40 + int'($urandom_range(5)), $urandom_range(3) != 0,
           $urandom_range(2) == 0, lid, fv, rdy, id, orig);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
